// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM: camera writes and DWT reads
// share one bus; each access is two cycles (x1 strobe, x2 hold/sample).
module sram_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 32,
  parameter int MAX_WR_BURST = 4
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] address_to_sram,
  inout  wire  [DATA_W-1:0] data_sram,
  output logic              write_en_n,
  output logic              output_en,
  output logic              chip_en,
  output logic [3:0]        byte_en,
  output logic              adv
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR1  = 3'd1;
  localparam logic [2:0] S_WR2  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_RD2  = 3'd4;

  localparam int         BW        = $clog2(MAX_WR_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [BW-1:0]     r_burst;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_arb_pt;
  logic              w_burst_full;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic              w_drive;

  // Decisions are taken in IDLE and in the hold cycle of each access so grants chain back-to-back.
  always_comb begin
    w_arb_pt     = (r_state == S_IDLE) || (r_state == S_WR2) || (r_state == S_RD2);
    w_burst_full = (r_burst == BURST_MAX);
    w_grant_wr   = w_arb_pt && wr_req && !(rd_req && w_burst_full);
    w_grant_rd   = w_arb_pt && rd_req && !w_grant_wr;
  end

  always_comb begin
    w_next = S_IDLE;
    if (w_grant_wr) begin
      w_next = S_WR1;
    end else if (w_grant_rd) begin
      w_next = S_RD1;
    end else begin
      case (r_state)
        S_WR1:   w_next = S_WR2;
        S_RD1:   w_next = S_RD2;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_rd || (w_next == S_IDLE)) begin
        r_burst <= '0;
      end else if (w_grant_wr && rd_req && !w_burst_full) begin
        r_burst <= r_burst + BW'(1);
      end
    end
  end

  // Address is captured at grant and left untouched until the next grant.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_grant_wr) begin
      r_addr <= wr_addr;
    end else if (w_grant_rd) begin
      r_addr <= rd_addr;
    end
  end

  always_ff @(posedge clk_100) begin
    if (w_grant_wr) begin
      r_wdata <= wr_data;
    end
  end

  // Read data is sampled at the edge closing RD2, after a full cycle of output enable.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == S_RD2);
      if (r_state == S_RD2) begin
        r_rd_data <= data_sram;
      end
    end
  end

  always_comb begin
    w_drive         = (r_state == S_WR1) || (r_state == S_WR2);
    busy            = (r_state != S_IDLE);
    chip_en         = (r_state == S_IDLE);
    write_en_n      = (r_state != S_WR1);
    output_en       = !((r_state == S_RD1) || (r_state == S_RD2));
    wr_ack          = (r_state == S_WR2);
    rd_valid        = r_rd_valid;
    rd_data         = r_rd_data;
    address_to_sram = r_addr;
    byte_en         = 4'b0000;
    adv             = 1'b0;
  end

  assign data_sram = w_drive ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the bus, scoreboard queues for
// writes (checked at WR2) and reads (checked at rd_valid).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [17:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [17:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [17:0] address_to_sram;
  wire  [31:0] data_sram;
  logic        write_en_n, output_en, chip_en, adv;
  logic [3:0]  byte_en;

  logic [31:0] sram [0:255];
  logic [31:0] refm [0:255];
  logic [31:0] rq [$];
  logic [63:0] wq [$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_we = 0, n_drv = 0, n_oe = 0, n_ack = 0, n_rv = 0;
  int oe_start = 0, rv_cyc = 0, prev_rv = 0;
  bit have_prev = 0, seq_on = 0, sb_on = 1, prev_oe = 1;

  sram_arbiter dut (
    .clk_100(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .address_to_sram(address_to_sram),
    .data_sram(data_sram), .write_en_n(write_en_n), .output_en(output_en),
    .chip_en(chip_en), .byte_en(byte_en), .adv(adv)
  );

  always #5 clk = ~clk;

  assign data_sram = (!chip_en && !output_en) ? sram[address_to_sram[7:0]] : {32{1'bz}};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Bus monitor and scoreboard consumers, all sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!write_en_n) n_we++;
    if (output_en && (data_sram !== {32{1'bz}})) n_drv++;
    if (!output_en) begin
      n_oe++;
      if (prev_oe) oe_start = cyc;
    end
    prev_oe = output_en;
    if (wr_ack) begin
      n_ack++;
      sram[address_to_sram[7:0]] = data_sram;
      if (sb_on) begin
        if (wq.size() == 0) check("wr_unexpected", 1, 0);
        else check("wr_sb", {14'd0, address_to_sram, data_sram}, wq.pop_front());
      end
    end
    if (rd_valid) begin
      n_rv++;
      rv_cyc = cyc;
      if (seq_on && have_prev) check("rv_gap", 64'(cyc - prev_rv), 2);
      prev_rv = cyc;
      have_prev = 1;
      if (sb_on) begin
        if (rq.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_sb", {32'd0, rd_data}, {32'd0, rq.pop_front()});
      end
    end
  end

  task automatic clr_counts();
    n_we = 0; n_drv = 0; n_oe = 0; n_ack = 0; n_rv = 0; have_prev = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_write(input logic [17:0] a, input logic [31:0] d);
    int t;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    refm[a[7:0]] = d;
    wq.push_back({14'd0, a, d});
    t = 0;
    while (write_en_n && t < 50) begin @(negedge clk); t++; end
    check("wr_grant", write_en_n, 0);
    wr_req = 1'b0;
    wait_cycles(3);
  endtask

  task automatic do_read(input logic [17:0] a);
    int t;
    rd_addr = a; rd_req = 1'b1;
    rq.push_back(refm[a[7:0]]);
    t = 0;
    while (output_en && t < 50) begin @(negedge clk); t++; end
    check("rd_grant", output_en, 0);
    rd_req = 1'b0;
    wait_cycles(4);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] got, exp;
    int t, slot;
    for (int i = 0; i < 256; i++) begin
      sram[i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
      refm[i] = sram[i];
    end

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_we_n", write_en_n, 1);
    check("rst_oe", output_en, 1);
    check("rst_ce", chip_en, 1);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_addr", address_to_sram, 0);
    check("rst_bus_z", data_sram === {32{1'bz}}, 1);
    check("byte_en", byte_en, 0);
    check("adv", adv, 0);
    rst = 1'b0;
    wait_cycles(2);

    // Single write then read back
    clr_counts();
    do_write(18'h00010, 32'hA5A5_5A5A);
    check("w1_we_cycles", n_we, 1);
    check("w1_drv_cycles", n_drv, 2);
    check("w1_ack_count", n_ack, 1);
    check("w1_sram", sram[8'h10], 32'hA5A5_5A5A);
    check("w1_addr_hold", address_to_sram, 18'h00010);
    check("w1_idle", busy, 0);
    clr_counts();
    do_read(18'h00010);
    check("r1_oe_cycles", n_oe, 2);
    check("r1_rv_count", n_rv, 1);
    check("r1_latency", rv_cyc - oe_start, 2);
    check("r1_data", rd_data, 32'hA5A5_5A5A);
    check("r1_drv", n_drv, 0);

    // Mixed traffic through the scoreboard
    for (int i = 0; i < 4; i++) do_write(18'(8'h50 + i * 3), $urandom);
    for (int i = 0; i < 4; i++) do_read(18'(8'h50 + i * 3));
    do_read(18'h000A7);

    // Both requests held: W,W,W,W,R with no idle cycle
    sb_on = 0;
    wr_addr = 18'h00080; wr_data = 32'hDEAD_BEEF; refm[8'h80] = 32'hDEAD_BEEF;
    rd_addr = 18'h00081;
    wr_req = 1'b1; rd_req = 1'b1;
    t = 0;
    while (write_en_n && t < 50) begin @(negedge clk); t++; end
    for (int k = 0; k < 30; k++) begin
      slot = (k / 2) % 5;
      exp = (slot == 4) ? 2'd3 : ((k % 2 == 0) ? 2'd1 : 2'd2);
      got = !write_en_n ? 2'd1 : (!output_en ? 2'd3 : (!chip_en ? 2'd2 : 2'd0));
      check($sformatf("burst_cyc%0d", k), got, exp);
      @(negedge clk);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    wait_cycles(6);
    check("burst_idle", busy, 0);
    sb_on = 1;

    // Eight sequential reads, request held throughout
    clr_counts();
    seq_on = 1;
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 18'(8'h20 + i);
      rq.push_back(refm[8'h20 + i]);
      t = 0;
      while (!(!output_en && address_to_sram == rd_addr) && t < 20) begin @(negedge clk); t++; end
      check("seq_grant", address_to_sram, rd_addr);
      if (i == 7) rd_req = 1'b0;
    end
    wait_cycles(6);
    seq_on = 0;
    check("seq_rv_count", n_rv, 8);
    check("seq_we", n_we, 0);
    check("seq_drv", n_drv, 0);

    // Reset during WR1 aborts, held request is re-granted afterwards
    clr_counts();
    wr_addr = 18'h00040; wr_data = 32'h1234_5678;
    refm[8'h40] = 32'h1234_5678;
    wq.push_back({14'd0, 18'h00040, 32'h1234_5678});
    wr_req = 1'b1;
    t = 0;
    while (write_en_n && t < 50) begin @(negedge clk); t++; end
    #1 rst = 1'b1;
    #1;
    check("abort_we_n", write_en_n, 1);
    check("abort_ce", chip_en, 1);
    check("abort_bus_z", data_sram === {32{1'bz}}, 1);
    check("abort_busy", busy, 0);
    wait_cycles(2);
    check("abort_no_ack", n_ack, 0);
    rst = 1'b0;
    t = 0;
    while (write_en_n && t < 50) begin @(negedge clk); t++; end
    check("regrant", write_en_n, 0);
    wr_req = 1'b0;
    wait_cycles(4);
    check("regrant_ack", n_ack, 1);
    check("regrant_sram", sram[8'h40], 32'h1234_5678);
    do_read(18'h00040);

    check("rq_empty", rq.size(), 0);
    check("wq_empty", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width.
REQ-003 SHALL have parameter MAX_WR_BURST, default 4, consecutive write grants allowed while a read is pending.
REQ-004 SHALL have port clk_100  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_req  input  1  camera-side write request, level, held until wr_ack.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write word address.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port wr_ack  output  1  one-cycle pulse, write completed.
REQ-010 SHALL have port rd_req  input  1  DWT-side read request, level, held until rd_valid.
REQ-011 SHALL have port rd_addr  input  ADDR_W  read word address.
REQ-012 SHALL have port rd_data  output  DATA_W  read data, valid with rd_valid, held until next read.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port address_to_sram  output  ADDR_W  SRAM address.
REQ-016 SHALL have port data_sram  inout  DATA_W  SRAM data bus.
REQ-017 SHALL have ports write_en_n, output_en, chip_en  output  1 each  SRAM strobes, active-low.
REQ-018 SHALL have ports byte_en (output, 4, constant 4'b0000) and adv (output, 1, constant 0).

Function
REQ-019 SHALL implement states IDLE, WR1, WR2, RD1, RD2; each access takes exactly 2 cycles (x1 then x2).
REQ-020 SHALL arbitrate in IDLE and in the last cycle of WR2/RD2, allowing back-to-back accesses with no idle cycle.
REQ-021 Arbitration: only wr_req -> WR1; only rd_req -> RD1; neither -> IDLE; both -> WR1 unless wr_burst_cnt == MAX_WR_BURST, then RD1.
REQ-022 wr_burst_cnt SHALL increment on each write grant made while rd_req is high, and clear to 0 on any read grant or on entering IDLE.
REQ-023 Address (and write data) SHALL be registered at grant and held stable on address_to_sram through both access cycles.
REQ-024 data_sram SHALL be driven with the latched data in WR1 and WR2 only, high-Z in all other states.
REQ-025 write_en_n SHALL be 0 in WR1 only (data held through WR2 for hold time), 1 otherwise.
REQ-026 output_en SHALL be 0 in RD1 and RD2, 1 otherwise; chip_en SHALL be 0 in all non-IDLE states.
REQ-027 wr_ack SHALL be 1 for exactly the WR2 cycle of each write.
REQ-028 rd_data SHALL capture data_sram at the clock edge ending RD2; rd_valid SHALL be 1 in the following cycle only (latency: grant edge +3 cycles).
REQ-029 A request deasserted before grant SHALL NOT be serviced; once granted, an access SHALL complete regardless of request level.
REQ-030 A requester holding its request after ack SHALL be treated as a new request at the next arbitration point.
REQ-031 address_to_sram in IDLE SHALL retain the last access address.

Reset
REQ-032 While rst is high: state IDLE, wr_burst_cnt 0, address_to_sram 0, rd_data 0, wr_ack 0, rd_valid 0, busy 0, write_en_n 1, output_en 1, chip_en 1, data_sram high-Z, all taking effect asynchronously.
REQ-033 Reset asserted mid-access SHALL abort the access immediately with no wr_ack/rd_valid produced; first grant is possible in the first cycle after rst deasserts.

Verification
REQ-034 Single write wr_addr=0x00010, wr_data=0xA5A5_5A5A -> write_en_n low 1 cycle, bus driven 2 cycles, wr_ack in WR2, model SRAM holds value.
REQ-035 Single read of 0x00010 after REQ-034 -> output_en low 2 cycles, rd_valid 3 cycles after grant, rd_data=0xA5A5_5A5A.
REQ-036 wr_req and rd_req held continuously, MAX_WR_BURST=4 -> grant pattern W,W,W,W,R repeating, no idle cycles between accesses.
REQ-037 rd_req only, 8 sequential addresses -> 8 rd_valid pulses every 2 cycles, data in address order, data_sram never driven.
REQ-038 rst asserted during WR1 -> write_en_n, chip_en immediately 1, bus high-Z, no wr_ack; after release pending wr_req re-granted.
